// File: rtl/leaf_stream_packetizer.sv
// Credit-flow-controlled stream packetizer: wraps 32-bit user words into 49-bit BFT packets.
// Optional replay of the last packet is enabled by defining LEAF_TX_RESEND_EN.
module leaf_stream_packetizer #(
    parameter logic [3:0]  DEST_LEAF   = 4'd0,
    parameter logic [3:0]  DEST_PORT   = 4'd2,
    parameter int unsigned CREDIT_INIT = 64
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [31:0] Input_1_V_TDATA,
    input  logic        Input_1_V_TVALID,
    output logic        Input_1_V_TREADY,
    output logic [48:0] dout_leaf_interface2bft,
    input  logic        credit_vld,
    input  logic [6:0]  credit_cnt,
    input  logic        resend,
    output logic        credit_err
);

    localparam logic [7:0] CreditInit = 8'(CREDIT_INIT);

`ifdef LEAF_TX_RESEND_EN
    typedef enum logic [1:0] {StIdle, StSend, StStall, StResend} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSend, StStall} state_e;
`endif

    state_e      state_q;
    logic [7:0]  credits_q, credits_d;
    logic [8:0]  credit_net;
    logic [6:0]  seq_q, seq_d;
    logic [48:0] dout_q, dout_d;
    logic [48:0] pkt;
    logic        err_q, err_d;
    logic        live_q;
    logic        accept;
    logic        in_resend;
    logic        resend_req;

`ifdef LEAF_TX_RESEND_EN
    state_e      ret_q;
    logic [48:0] replay_q, replay_d;
    assign resend_req = resend;
    assign in_resend  = (state_q == StResend);
`else
    logic unused_resend;
    assign unused_resend = resend;
    assign resend_req    = 1'b0;
    assign in_resend     = 1'b0;
`endif

    // live_q keeps TREADY low while reset is held, since credits reset to a nonzero value.
    assign Input_1_V_TREADY = live_q && (credits_q != 8'd0) && !in_resend && !resend_req;
    assign accept           = Input_1_V_TVALID && Input_1_V_TREADY;
    assign pkt              = {1'b1, DEST_LEAF, DEST_PORT, seq_q, 1'b0, Input_1_V_TDATA};
    assign credit_net       = {1'b0, credits_q} - 9'(accept)
                            + (credit_vld ? {2'b00, credit_cnt} : 9'd0);

    always_comb begin
        credits_d = credit_net[7:0];
        err_d     = err_q;
        if (credit_net > {1'b0, CreditInit}) begin
            credits_d = CreditInit;
            err_d     = 1'b1;
        end
        seq_d  = accept ? seq_q + 7'd1 : seq_q;
        dout_d = '0;
        if (accept) begin
            dout_d = pkt;
        end
`ifdef LEAF_TX_RESEND_EN
        // An empty replay register is all zeros, so a resend before any packet emits nothing.
        else if (resend_req) begin
            dout_d = replay_q;
        end
        replay_d = accept ? pkt : replay_q;
`endif
    end

    function automatic state_e next_state(input state_e st, input logic tvalid,
                                          input logic cred_nz);
        state_e ns;
        ns = st;
        unique case (st)
            StIdle:  if (tvalid) ns = cred_nz ? StSend : StStall;
            StSend:  ns = !tvalid ? StIdle : (cred_nz ? StSend : StStall);
            StStall: if (cred_nz) ns = StSend;
            default: ns = StIdle;
        endcase
        return ns;
    endfunction

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
`ifdef LEAF_TX_RESEND_EN
            ret_q   <= StIdle;
        end else if (resend) begin
            state_q <= StResend;
            if (state_q != StResend) ret_q <= state_q;
        end else if (state_q == StResend) begin
            state_q <= next_state(ret_q, Input_1_V_TVALID, credits_q != 8'd0);
`endif
        end else begin
            state_q <= next_state(state_q, Input_1_V_TVALID, credits_q != 8'd0);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credits_q <= CreditInit;
            seq_q     <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            live_q    <= 1'b0;
`ifdef LEAF_TX_RESEND_EN
            replay_q  <= '0;
`endif
        end else begin
            credits_q <= credits_d;
            seq_q     <= seq_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            live_q    <= 1'b1;
`ifdef LEAF_TX_RESEND_EN
            replay_q  <= replay_d;
`endif
        end
    end

    assign dout_leaf_interface2bft = dout_q;
    assign credit_err              = err_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Scoreboard bench for leaf_stream_packetizer: a packet-level model predicts every emitted
// packet, TREADY and credit_err; a monitor compares packets as they appear.
module tb_leaf_stream_packetizer;

    localparam logic [3:0] DL = 4'd5;
    localparam logic [3:0] DP = 4'd9;
    localparam int         CI = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [48:0] dout;
    logic        cvld = 1'b0;
    logic [6:0]  ccnt = '0;
    logic        resend = 1'b0;
    logic        cerr;

    leaf_stream_packetizer #(
        .DEST_LEAF  (DL),
        .DEST_PORT  (DP),
        .CREDIT_INIT(CI)
    ) dut (
        .ap_clk                 (clk),
        .ap_rst_n               (rst_n),
        .Input_1_V_TDATA        (tdata),
        .Input_1_V_TVALID       (tvalid),
        .Input_1_V_TREADY       (tready),
        .dout_leaf_interface2bft(dout),
        .credit_vld             (cvld),
        .credit_cnt             (ccnt),
        .resend                 (resend),
        .credit_err             (cerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [48:0] pkt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model state
    int          m_cred;
    int          m_seq;
    bit          m_err;
    bit          m_prev_rs;
    bit          m_have_last;
    logic [48:0] m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cred      = CI;
        m_seq       = 0;
        m_err       = 1'b0;
        m_prev_rs   = 1'b0;
        m_have_last = 1'b0;
        m_last      = '0;
    endtask

    // Monitor: one packet or an all-zero bus after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_pkt: got none expected %h (cycle %0d)", e.pkt, e.cyc);
                end
                if (dout[48]) begin
                    if (q.size() > 0 && q[0].cyc == cyc) begin
                        e = q.pop_front();
                        check("packet", 64'(dout), 64'(e.pkt));
                    end else begin
                        check("unexpected_pkt", 64'(dout), 64'd0);
                    end
                end else if (!(q.size() > 0 && q[0].cyc == cyc)) begin
                    check("idle_zero", 64'(dout), 64'd0);
                end
            end
        end
    end

    task automatic step(input bit tv, input logic [31:0] data, input bit cv, input int c,
                        input bit rs);
        bit          exp_ready;
        bit          acc;
        int          net;
        exp_t        e;
        @(negedge clk);
        tvalid = tv;
        tdata  = data;
        cvld   = cv;
        ccnt   = 7'(c);
        resend = rs;
        #1;
`ifdef LEAF_TX_RESEND_EN
        exp_ready = (m_cred != 0) && !m_prev_rs && !rs;
`else
        exp_ready = (m_cred != 0);
`endif
        check("tready", 64'(tready), 64'(exp_ready));
        check("credit_err", 64'(cerr), 64'(m_err));
        acc = tv && exp_ready;
        if (acc) begin
            e.cyc = cyc + 1;
            e.pkt = {1'b1, DL, DP, 7'(m_seq), 1'b0, data};
            q.push_back(e);
            m_last      = e.pkt;
            m_have_last = 1'b1;
            m_seq       = (m_seq + 1) % 128;
        end
`ifdef LEAF_TX_RESEND_EN
        else if (rs && m_have_last) begin
            e.cyc = cyc + 1;
            e.pkt = m_last;
            q.push_back(e);
        end
        m_prev_rs = rs;
`endif
        net = m_cred - (acc ? 1 : 0) + (cv ? c : 0);
        if (net > CI) begin
            m_cred = CI;
            m_err  = 1'b1;
        end else begin
            m_cred = net;
        end
    endtask

    task automatic rand_step(input bit allow_ovf);
        int c;
        c = $urandom_range(0, allow_ovf ? 10 : 2);
        if (!allow_ovf && m_cred + c > CI) c = 0;
        step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, c,
             $urandom_range(0, 19) == 0);
    endtask

    // Asserts reset between edges so any word accepted at the coming edge is discarded.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_err", 64'(cerr), 64'd0);
        q.delete();
        model_reset();
        tvalid = 1'b0;
        cvld   = 1'b0;
        resend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        // Fill the credit window, stall, then release one credit.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 0, 1'b0);
        step(1'b1, 32'hA4, 1'b0, 0, 1'b0);
        step(1'b1, 32'hA4, 1'b1, 1, 1'b0);
        step(1'b1, 32'hA4, 1'b0, 0, 1'b0);
        // Resend of the last packet, then an idle cycle.
        step(1'b0, 32'h0, 1'b0, 0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 2, 1'b0);
        // Same-cycle accept and return, then overflow.
        step(1'b1, 32'hB0, 1'b1, 2, 1'b0);
        step(1'b0, 32'h0, 1'b1, 10, 1'b0);
        step(1'b0, 32'h0, 1'b0, 0, 1'b0);
        do_reset();
        step(1'b0, 32'h0, 1'b0, 0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 800; i++) rand_step(1'b0);
        do_reset();
        for (int i = 0; i < 300; i++) rand_step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
